// File: rtl/edge_level_decoder.sv
// edge_level_decoder: rebuilds a level waveform from rising/falling edge event
// pulses, measures each completed high/low phase in cycles, and hands the
// measurements out through a single-entry valid/ready output register.
// Protocol violations (duplicate or simultaneous edges) are flagged.
module edge_level_decoder #(
    parameter int   CNT_W      = 16,
    parameter logic INIT_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_posedge,
    input  logic             in_negedge,
    output logic             level_out,
    output logic             width_valid,
    input  logic             width_ready,
    output logic [CNT_W-1:0] width_data,
    output logic             width_is_high,
    output logic             err_dup,
    output logic             err_both,
    output logic             overflow
);

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             level_reg, level_next;
    logic             valid_reg, valid_next;
    logic [CNT_W-1:0] data_reg, data_next;
    logic             is_high_reg, is_high_next;
    logic             err_dup_reg, err_dup_next;
    logic             err_both_reg, err_both_next;
    logic             overflow_reg, overflow_next;

    logic pos_only, neg_only, legal_edge, meas_fire;

    // Edge classification, next state, phase counter and output register update.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        level_next    = level_reg;
        valid_next    = valid_reg;
        data_next     = data_reg;
        is_high_next  = is_high_reg;
        err_dup_next  = 1'b0;
        err_both_next = 1'b0;
        overflow_next = overflow_reg;

        pos_only   = in_posedge & ~in_negedge;
        neg_only   = in_negedge & ~in_posedge;
        legal_edge = 1'b0;
        meas_fire  = 1'b0;

        if (in_posedge && in_negedge) begin
            // Ambiguous event: ignore it entirely, only report it.
            err_both_next = 1'b1;
        end else if (pos_only) begin
            if (state_reg == ST_HIGH) begin
                err_dup_next = 1'b1;
            end else begin
                legal_edge = 1'b1;
                meas_fire  = (state_reg == ST_LOW);
                state_next = ST_HIGH;
            end
        end else if (neg_only) begin
            if (state_reg == ST_LOW) begin
                err_dup_next = 1'b1;
            end else begin
                legal_edge = 1'b1;
                meas_fire  = (state_reg == ST_HIGH);
                state_next = ST_LOW;
            end
        end

        // Counter restarts at 1 on a legal edge so that edges K cycles apart read K.
        if (legal_edge) begin
            cnt_next = CNT_ONE;
        end else if (state_reg != ST_SYNC && cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_ONE;
        end

        case (state_next)
            ST_HIGH: level_next = 1'b1;
            ST_LOW:  level_next = 1'b0;
            default: level_next = INIT_LEVEL;
        endcase

        // A full register with a stalled consumer drops the new measurement.
        if (meas_fire) begin
            if (!valid_reg || width_ready) begin
                valid_next   = 1'b1;
                data_next    = cnt_reg;
                is_high_next = (state_reg == ST_HIGH);
            end else begin
                overflow_next = 1'b1;
            end
        end else if (valid_reg && width_ready) begin
            valid_next = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_SYNC;
            cnt_reg      <= '0;
            level_reg    <= INIT_LEVEL;
            valid_reg    <= 1'b0;
            data_reg     <= '0;
            is_high_reg  <= 1'b0;
            err_dup_reg  <= 1'b0;
            err_both_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            level_reg    <= level_next;
            valid_reg    <= valid_next;
            data_reg     <= data_next;
            is_high_reg  <= is_high_next;
            err_dup_reg  <= err_dup_next;
            err_both_reg <= err_both_next;
            overflow_reg <= overflow_next;
        end
    end

    assign level_out     = level_reg;
    assign width_valid   = valid_reg;
    assign width_data    = data_reg;
    assign width_is_high = is_high_reg;
    assign err_dup       = err_dup_reg;
    assign err_both      = err_both_reg;
    assign overflow      = overflow_reg;

endmodule

// File: tb/tb_edge_level_decoder.sv
// Randomized bench for edge_level_decoder. Two instances share the stimulus:
// a default one (16-bit counter, idle level 0) and a narrow one (4-bit
// counter, idle level 1) so saturation is exercised. Expected values come
// from a timestamp-based model: a phase length is the difference between the
// cycle numbers of the two bounding legal edges, capped at the counter range.
module tb_edge_level_decoder;

    logic clk = 1'b0;
    logic rst, in_posedge, in_negedge, width_ready;

    logic        a_level, a_valid, a_is_high, a_dup, a_both, a_ovf;
    logic [15:0] a_data;
    logic        b_level, b_valid, b_is_high, b_dup, b_both, b_ovf;
    logic [3:0]  b_data;

    always #5 clk = ~clk;

    edge_level_decoder #(.CNT_W(16), .INIT_LEVEL(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_posedge(in_posedge), .in_negedge(in_negedge),
        .level_out(a_level), .width_valid(a_valid), .width_ready(width_ready),
        .width_data(a_data), .width_is_high(a_is_high), .err_dup(a_dup),
        .err_both(a_both), .overflow(a_ovf)
    );

    edge_level_decoder #(.CNT_W(4), .INIT_LEVEL(1'b1)) dut_b (
        .clk(clk), .rst(rst), .in_posedge(in_posedge), .in_negedge(in_negedge),
        .level_out(b_level), .width_valid(b_valid), .width_ready(width_ready),
        .width_data(b_data), .width_is_high(b_is_high), .err_dup(b_dup),
        .err_both(b_both), .overflow(b_ovf)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: level as -1 (unknown) / 0 / 1, and a timestamp of the
    // last legal edge. A pending measurement keeps its uncapped length.
    int     m_lvl;
    longint m_last, m_w, cyc;
    bit     m_pv, m_hi, m_dup, m_both, m_ovf;
    int     n_xfer = 0;

    function automatic longint cap(input longint w, input int bits);
        longint mx;
        mx = (longint'(1) << bits) - 1;
        return (w > mx) ? mx : w;
    endfunction

    task automatic model_step(input bit r, input bit p, input bit n, input bit rdy);
        bit     xfer, meas;
        int     new_lvl;
        longint w;
        if (r) begin
            m_lvl = -1; m_pv = 0; m_w = 0; m_hi = 0;
            m_dup = 0; m_both = 0; m_ovf = 0; m_last = cyc;
            return;
        end
        xfer = m_pv && rdy;
        m_dup = 0; m_both = 0; meas = 0; w = 0;
        new_lvl = m_lvl;
        if (p && n) m_both = 1;
        else if (p || n) begin
            new_lvl = p ? 1 : 0;
            if (m_lvl == new_lvl) m_dup = 1;
            else begin
                if (m_lvl != -1) begin
                    meas = 1;
                    w = cyc - m_last;
                end
                m_last = cyc;
            end
        end
        if (xfer)
            $display("xfer #%0d cyc=%0d width=%0d high=%0d", n_xfer++, cyc, m_w, m_hi);
        if (meas) begin
            if (!m_pv || rdy) begin
                m_pv = 1; m_w = w; m_hi = (m_lvl == 1);
            end else m_ovf = 1;
        end else if (xfer) m_pv = 0;
        if (!m_dup && !m_both) m_lvl = new_lvl;
    endtask

    task automatic check_all();
        chk("a_level", a_level, (m_lvl == -1) ? 0 : m_lvl);
        chk("a_valid", a_valid, m_pv);
        chk("a_data", a_data, cap(m_w, 16));
        chk("a_is_high", a_is_high, m_hi);
        chk("a_err_dup", a_dup, m_dup);
        chk("a_err_both", a_both, m_both);
        chk("a_overflow", a_ovf, m_ovf);
        chk("b_level", b_level, (m_lvl == -1) ? 1 : m_lvl);
        chk("b_valid", b_valid, m_pv);
        chk("b_data", b_data, cap(m_w, 4));
        chk("b_is_high", b_is_high, m_hi);
        chk("b_err_dup", b_dup, m_dup);
        chk("b_err_both", b_both, m_both);
        chk("b_overflow", b_ovf, m_ovf);
    endtask

    initial begin
        int hold, rdy_len, r;
        rst = 1; in_posedge = 0; in_negedge = 0; width_ready = 1;
        cyc = 0; hold = 0; rdy_len = 10;
        m_lvl = -1; m_last = 0; m_w = 0; m_pv = 0; m_hi = 0;
        m_dup = 0; m_both = 0; m_ovf = 0;

        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            cyc++;
            model_step(rst, in_posedge, in_negedge, width_ready);
            #1;
            if (i > 0) check_all();

            // Next-cycle stimulus.
            rst = (i < 2) || ($urandom_range(0, 299) == 0);
            in_posedge = 0; in_negedge = 0;
            if (hold > 0) hold--;
            else if ($urandom_range(0, 39) == 0) hold = $urandom_range(16, 40);
            else begin
                r = $urandom_range(0, 99);
                if (r < 14) begin
                    if (m_lvl == 1) in_negedge = 1;
                    else if (m_lvl == 0) in_posedge = 1;
                    else if ($urandom_range(0, 1) == 1) in_posedge = 1;
                    else in_negedge = 1;
                end else if (r < 17) begin
                    if (m_lvl == 1) in_posedge = 1; else in_negedge = 1;
                end else if (r < 19) begin
                    in_posedge = 1; in_negedge = 1;
                end
            end
            if (rdy_len > 0) rdy_len--;
            else begin
                width_ready = ($urandom_range(0, 2) != 0);
                rdy_len = $urandom_range(1, 25);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
